// File: rtl/adder_rr_arbiter.sv
// adder_rr_arbiter: shares one registered DW-bit adder (1-cycle latency)
// between NUM_REQ requesters. Round-robin grant, registered issue stage,
// tagged return stage and one held response slot per requester.
//
// Handshake semantics (all ports): a transfer happens on a rising edge where
// valid && ready are both high. valid never depends on ready. Once asserted,
// resp_valid[i] and resp_sum[i] stay stable until the transfer. req_ready[i]
// is only asserted together with req_valid[i] and is at most one-hot.
module adder_rr_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int DW      = 9
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [NUM_REQ-1:0]         req_valid,
  output logic [NUM_REQ-1:0]         req_ready,
  input  logic [NUM_REQ*DW-1:0]      req_a,
  input  logic [NUM_REQ*DW-1:0]      req_b,
  output logic [NUM_REQ-1:0]         resp_valid,
  input  logic [NUM_REQ-1:0]         resp_ready,
  output logic [NUM_REQ*(DW+1)-1:0]  resp_sum,
  output logic                       add_in_valid,
  output logic [DW-1:0]              add_data_in0,
  output logic [DW-1:0]              add_data_in1,
  input  logic [DW:0]                add_data_out,
  input  logic                       add_out_valid,
  output logic                       err_unexpected,
  output logic [15:0]                ops_done
);

  localparam int PW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  logic [NUM_REQ-1:0] busy;
  logic [NUM_REQ-1:0] elig;
  logic [NUM_REQ-1:0] grant;
  logic [NUM_REQ-1:0] resp_hs;
  logic [PW-1:0]      ptr;
  logic [PW-1:0]      gidx;
  logic [PW-1:0]      tag_s1;
  logic [PW-1:0]      tag_s2;
  logic               vld_s2;
  logic               accept;
  logic [DW-1:0]      sel_a;
  logic [DW-1:0]      sel_b;
  logic [15:0]        hs_cnt;

  // Reset gates eligibility so req_ready reads zero while rst_n is low.
  assign elig      = req_valid & ~busy & {NUM_REQ{rst_n}};
  assign resp_hs   = resp_valid & resp_ready;
  assign req_ready = grant;
  assign accept    = |grant;
  assign sel_a     = req_a[int'(gidx)*DW +: DW];
  assign sel_b     = req_b[int'(gidx)*DW +: DW];

  // Round-robin pick: scan from farthest to nearest so the requester closest
  // after ptr overwrites any earlier candidate.
  always_comb begin
    int idx;
    idx   = 0;
    grant = '0;
    gidx  = '0;
    for (int k = NUM_REQ; k >= 1; k--) begin
      idx = (int'(ptr) + k) % NUM_REQ;
      if (elig[idx]) begin
        grant      = '0;
        grant[idx] = 1'b1;
        gidx       = PW'(idx);
      end
    end
  end

  // Number of response handshakes completing this cycle.
  always_comb begin
    hs_cnt = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hs_cnt = hs_cnt + 16'(resp_hs[i]);
    end
  end

  // Arbitration pointer: follows the last accepted requester, holds when idle.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr <= PW'(NUM_REQ - 1);
    end else if (accept) begin
      ptr <= gidx;
    end
  end

  // Issue stage S1: registered adder controls and the tag of the operation.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      add_in_valid <= 1'b0;
      add_data_in0 <= '0;
      add_data_in1 <= '0;
      tag_s1       <= '0;
    end else begin
      add_in_valid <= accept;
      add_data_in0 <= accept ? sel_a : '0;
      add_data_in1 <= accept ? sel_b : '0;
      tag_s1       <= gidx;
    end
  end

  // Return stage S2: delays valid/tag one cycle to line up with add_data_out.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_s2 <= 1'b0;
      tag_s2 <= '0;
    end else begin
      vld_s2 <= add_in_valid;
      tag_s2 <= tag_s1;
    end
  end

  // Busy flags and response slots. busy[i] stays set from acceptance through
  // the response handshake, so a new result can never overwrite a held one.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      busy       <= '0;
      resp_valid <= '0;
      resp_sum   <= '0;
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (grant[i]) begin
          busy[i] <= 1'b1;
        end else if (resp_hs[i]) begin
          busy[i] <= 1'b0;
        end
        if (add_out_valid && vld_s2 && (int'(tag_s2) == i)) begin
          resp_valid[i]                   <= 1'b1;
          resp_sum[i*(DW+1) +: (DW+1)]    <= add_data_out;
        end else if (resp_hs[i]) begin
          resp_valid[i] <= 1'b0;
        end
      end
    end
  end

  // Sticky error when the adder's valid disagrees with what was issued.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_unexpected <= 1'b0;
    end else if (add_out_valid != vld_s2) begin
      err_unexpected <= 1'b1;
    end
  end

  // Completed-operation counter, wraps at 16 bits.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ops_done <= '0;
    end else begin
      ops_done <= ops_done + hs_cnt;
    end
  end

endmodule

// File: tb/tb_adder_rr_arbiter.sv
// Directed testbench for adder_rr_arbiter with a behavioural 1-cycle adder,
// per-requester expected-sum queues and a final report.
module tb_adder_rr_arbiter;

  localparam int NUM_REQ = 4;
  localparam int DW      = 9;

  logic                      clk;
  logic                      rst_n;
  logic [NUM_REQ-1:0]        req_valid;
  logic [NUM_REQ-1:0]        req_ready;
  logic [NUM_REQ*DW-1:0]     req_a;
  logic [NUM_REQ*DW-1:0]     req_b;
  logic [NUM_REQ-1:0]        resp_valid;
  logic [NUM_REQ-1:0]        resp_ready;
  logic [NUM_REQ*(DW+1)-1:0] resp_sum;
  logic                      add_in_valid;
  logic [DW-1:0]             add_data_in0;
  logic [DW-1:0]             add_data_in1;
  logic [DW:0]               add_data_out;
  logic                      add_out_valid;
  logic                      err_unexpected;
  logic [15:0]               ops_done;

  logic                      ov_r;
  logic                      force_ov;

  int n_checks;
  int n_fail;

  logic [DW:0] exp_q [NUM_REQ][$];

  adder_rr_arbiter #(.NUM_REQ(NUM_REQ), .DW(DW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_a          (req_a),
    .req_b          (req_b),
    .resp_valid     (resp_valid),
    .resp_ready     (resp_ready),
    .resp_sum       (resp_sum),
    .add_in_valid   (add_in_valid),
    .add_data_in0   (add_data_in0),
    .add_data_in1   (add_data_in1),
    .add_data_out   (add_data_out),
    .add_out_valid  (add_out_valid),
    .err_unexpected (err_unexpected),
    .ops_done       (ops_done)
  );

  // Clock / reset block
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached, got no finish, expected finish");
    $fatal(1, "watchdog");
  end

  // Behavioural registered adder, reset together with the DUT.
  always @(posedge clk) begin
    if (!rst_n) begin
      ov_r         <= 1'b0;
      add_data_out <= '0;
    end else begin
      ov_r         <= add_in_valid;
      add_data_out <= {1'b0, add_data_in0} + {1'b0, add_data_in1};
    end
  end
  assign add_out_valid = ov_r | force_ov;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [DW:0] sum_of(input int i);
    return resp_sum[i*(DW+1) +: (DW+1)];
  endfunction

  // Driver tasks
  task automatic tick();
    @(negedge clk);
  endtask

  task automatic set_op(input int i, input int a, input int b);
    req_a[i*DW +: DW] = a[DW-1:0];
    req_b[i*DW +: DW] = b[DW-1:0];
  endtask

  task automatic apply_reset();
    rst_n     = 1'b0;
    req_valid = '0;
    tick();
    tick();
    check("rst_req_ready",  req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_sum",   (resp_sum == '0), 1);
    check("rst_add_in_vld", add_in_valid, 0);
    check("rst_add_in0",    add_data_in0, 0);
    check("rst_add_in1",    add_data_in1, 0);
    check("rst_err",        err_unexpected, 0);
    check("rst_ops_done",   ops_done, 0);
    rst_n = 1'b1;
    tick();
  endtask

  // One isolated operation with cycle-exact latency checks; returns one
  // cycle after the response handshake.
  task automatic do_single(input int i, input int a, input int b, input int exp_sum);
    logic [NUM_REQ-1:0] onehot;
    onehot     = NUM_REQ'(1) << i;
    set_op(i, a, b);
    resp_ready = '1;
    req_valid  = onehot;
    #1;
    check("single_ready", req_ready, onehot);
    tick();
    req_valid = '0;
    check("single_t1_vld", add_in_valid, 1);
    check("single_t1_a",   add_data_in0, a);
    check("single_t1_b",   add_data_in1, b);
    tick();
    check("single_t2_resp", resp_valid, 0);
    tick();
    check("single_t3_resp", resp_valid, onehot);
    check("single_t3_sum",  sum_of(i), exp_sum);
    tick();
    check("single_t4_resp", resp_valid, 0);
    check("single_t4_hold", sum_of(i), exp_sum);
  endtask

  // Scoreboard: record accepted operations, compare on response handshakes.
  always begin
    logic [DW:0] s;
    @(negedge clk);
    #4;
    if (!rst_n) begin
      for (int i = 0; i < NUM_REQ; i++) exp_q[i].delete();
    end else begin
      for (int i = 0; i < NUM_REQ; i++) begin
        if (resp_valid[i] && resp_ready[i]) begin
          if (exp_q[i].size() == 0) begin
            check("sb_q_nonempty", exp_q[i].size(), 1);
          end else begin
            check("sb_sum", sum_of(i), exp_q[i].pop_front());
          end
        end
        if (req_valid[i] && req_ready[i]) begin
          s = {1'b0, req_a[i*DW +: DW]} + {1'b0, req_b[i*DW +: DW]};
          exp_q[i].push_back(s);
        end
      end
    end
  end

  logic [NUM_REQ-1:0] rr_exp [8];
  logic [NUM_REQ-1:0] bp_exp [12];

  initial begin
    n_checks   = 0;
    n_fail     = 0;
    rst_n      = 1'b0;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = '1;
    force_ov   = 1'b0;

    rr_exp = '{4'b0001, 4'b0010, 4'b0100, 4'b1000,
               4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bp_exp = '{4'b0100, 4'b1000, 4'b0001, 4'b0000,
               4'b0100, 4'b1000, 4'b0001, 4'b0000,
               4'b0100, 4'b1000, 4'b0001, 4'b0000};

    // Reset state and single request
    apply_reset();
    do_single(2, 100, 27, 127);
    check("single_ops_done", ops_done, 1);

    // Round robin from a fresh reset: 0,1,2,3 then 0 again right after its
    // response handshake.
    apply_reset();
    for (int i = 0; i < NUM_REQ; i++) set_op(i, i * 10 + 1, i + 5);
    req_valid = '1;
    for (int k = 0; k < 8; k++) begin
      #1;
      check("rr_grant", req_ready, rr_exp[k]);
      tick();
    end
    req_valid = '0;
    repeat (4) tick();
    check("rr_ops_done", ops_done, 8);

    // Operand extremes
    do_single(0, 511, 511, 1022);
    do_single(0, 0, 0, 0);
    check("max_ops_done", ops_done, 10);

    // Back-pressure on requester 1 while 0, 2, 3 keep completing
    set_op(0, 10, 20);
    set_op(1, 200, 100);
    set_op(2, 300, 211);
    set_op(3, 400, 111);
    resp_ready = 4'b1101;
    req_valid  = 4'b0010;
    #1;
    check("bp_grant1", req_ready, 4'b0010);
    tick();
    req_valid = '1;
    for (int k = 0; k < 12; k++) begin
      #1;
      check("bp_grant", req_ready, bp_exp[k]);
      if (k >= 2) begin
        check("bp_hold_vld", resp_valid[1], 1);
        check("bp_hold_sum", sum_of(1), 300);
      end
      tick();
    end
    req_valid  = '0;
    resp_ready = '1;
    repeat (5) tick();
    check("bp_ops_done", ops_done, 20);
    check("bp_resp_idle", resp_valid, 0);

    // Reset while operations for 0 and 3 are in flight
    req_valid = 4'b0001;
    #1;
    check("mid_grant0", req_ready, 4'b0001);
    tick();
    req_valid = 4'b1000;
    #1;
    check("mid_grant3", req_ready, 4'b1000);
    tick();
    req_valid = '0;
    rst_n     = 1'b0;
    #1;
    check("mid_rst_ready", req_ready, 0);
    tick();
    check("mid_rst_resp",  resp_valid, 0);
    check("mid_rst_issue", add_in_valid, 0);
    check("mid_rst_sum",   (resp_sum == '0), 1);
    check("mid_rst_ops",   ops_done, 0);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mid_post_resp", resp_valid, 0);
      check("mid_post_err",  err_unexpected, 0);
    end
    set_op(0, 5, 6);
    req_valid = '1;
    #1;
    check("mid_first_grant", req_ready, 4'b0001);
    tick();
    req_valid = '0;
    repeat (4) tick();
    check("mid_sum0",   sum_of(0), 11);
    check("mid_ops",    ops_done, 1);
    check("mid_resp",   resp_valid, 0);

    // Spurious adder output while idle
    check("spur_err_before", err_unexpected, 0);
    force_ov = 1'b1;
    tick();
    force_ov = 1'b0;
    check("spur_err_set", err_unexpected, 1);
    check("spur_resp",    resp_valid, 0);
    repeat (3) tick();
    check("spur_err_sticky", err_unexpected, 1);
    check("spur_resp_late",  resp_valid, 0);
    check("spur_sum0",       sum_of(0), 11);
    check("spur_ops",        ops_done, 1);

    for (int i = 0; i < NUM_REQ; i++) check("sb_left", exp_q[i].size(), 0);

    // Final report
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
